// File: rtl/clock_display_driver.sv
//==============================================================================
// Module   : clock_display_driver
// Brief    : Synchronises the time-keeping counters, converts minutes to BCD
//            with a sequential double-dabble and scans a 3-digit active-low
//            7-segment display.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module clock_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] minutes,
    input  logic       hours,
    input  logic       sec,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic       conv_done
);

    localparam int                 c_CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]         c_LAST_ITER = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t             r_state;
    logic [6:0]         r_w_s1;
    logic [6:0]         r_w_s2;
    logic               r_sec_s1;
    logic               r_sec_s2;
    logic [6:0]         r_word;
    logic [6:0]         r_last_word;
    logic [13:0]        r_shift;
    logic [2:0]         r_iter;
    logic               r_hour_digit;
    logic [c_CNT_W-1:0] r_refresh_cnt;
    logic [1:0]         r_digit_sel;

    logic               w_start;
    logic [3:0]         w_tens_adj;
    logic [3:0]         w_ones_adj;
    logic [13:0]        w_shift_next;
    logic [3:0]         w_digit_val;
    logic               w_blank;
    logic [3:0]         w_an;
    logic [6:0]         w_seg;

    // hours and minutes travel as one word so a simultaneous change is
    // accepted only once both flops agree, rejecting multi-bit skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_s1   <= '0;
            r_w_s2   <= '0;
            r_sec_s1 <= 1'b0;
            r_sec_s2 <= 1'b0;
        end else begin
            r_w_s1   <= {hours, minutes};
            r_w_s2   <= r_w_s1;
            r_sec_s1 <= sec;
            r_sec_s2 <= r_sec_s1;
        end
    end

    assign w_start = (r_w_s2 == r_w_s1) && (r_w_s2 != r_last_word);

    always_comb begin
        w_tens_adj   = (r_shift[13:10] >= 4'd5) ? (r_shift[13:10] + 4'd3) : r_shift[13:10];
        w_ones_adj   = (r_shift[9:6]   >= 4'd5) ? (r_shift[9:6]   + 4'd3) : r_shift[9:6];
        w_shift_next = {w_tens_adj, w_ones_adj, r_shift[5:0]} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_word       <= '0;
            r_last_word  <= '0;
            r_shift      <= '0;
            r_iter       <= '0;
            r_hour_digit <= 1'b0;
            min_tens     <= '0;
            min_ones     <= '0;
            conv_done    <= 1'b0;
        end else begin
            conv_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_word  <= r_w_s2;
                        r_shift <= {8'd0, r_w_s2[5:0]};
                        r_iter  <= '0;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shift <= w_shift_next;
                    r_iter  <= r_iter + 3'd1;
                    if (r_iter == c_LAST_ITER) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // All displayed fields change together so the hour digit
                    // can never pair with stale minutes.
                    min_tens     <= r_shift[13:10];
                    min_ones     <= r_shift[9:6];
                    r_hour_digit <= r_word[6];
                    r_last_word  <= r_word;
                    conv_done    <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        case (r_digit_sel)
            2'd0:    w_digit_val = min_ones;
            2'd1:    w_digit_val = min_tens;
            default: w_digit_val = {3'b000, r_hour_digit};
        endcase
        case (r_digit_sel)
            2'd0:    w_an = 4'b1110;
            2'd1:    w_an = 4'b1101;
            2'd2:    w_an = 4'b1011;
            default: w_an = 4'b1111;
        endcase
        w_blank = LZ_BLANK && (r_digit_sel == 2'd1) && (min_tens == 4'd0);
        w_seg   = w_blank ? 7'b1111111 : seg_encode(w_digit_val);
    end

    // an, seg and dp are all registered from the same digit_sel value so the
    // anode and its segment pattern switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_digit_sel   <= '0;
            an            <= 4'b1111;
            seg           <= 7'b1111111;
            dp            <= 1'b1;
        end else begin
            if (r_refresh_cnt == c_CNT_MAX) begin
                r_refresh_cnt <= '0;
                r_digit_sel   <= (r_digit_sel == 2'd2) ? 2'd0 : (r_digit_sel + 2'd1);
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
            an  <= w_an;
            seg <= w_seg;
            dp  <= ~((r_digit_sel == 2'd2) && r_sec_s2);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clock_display_driver.sv
//==============================================================================
// Module   : tb_clock_display_driver
// Brief    : Self-checking bench for clock_display_driver with a behavioural
//            reference for BCD conversion, digit scanning and the seconds dp.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clock_display_driver;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] minutes = 6'd0;
    logic       hours = 1'b0;
    logic       sec = 1'b0;

    logic [3:0] an, an_b;
    logic [6:0] seg, seg_b;
    logic       dp, dp_b;
    logic [3:0] mt, mo, mt_b, mo_b;
    logic       cd, cd_b;

    int checks = 0;
    int failures = 0;

    // Edges since reset release and the seconds level seen at recent edges.
    int         edges = 0;
    logic [2:0] sec_hist = 3'b000;
    int         last_m = 0;
    int         last_h = 0;

    always #5 clk = ~clk;

    clock_display_driver #(.REFRESH_DIV(RD), .LZ_BLANK(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .minutes(minutes), .hours(hours), .sec(sec),
        .an(an), .seg(seg), .dp(dp), .min_tens(mt), .min_ones(mo), .conv_done(cd)
    );

    clock_display_driver #(.REFRESH_DIV(RD), .LZ_BLANK(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .minutes(minutes), .hours(hours), .sec(sec),
        .an(an_b), .seg(seg_b), .dp(dp_b), .min_tens(mt_b), .min_ones(mo_b), .conv_done(cd_b)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges    <= 0;
            sec_hist <= 3'b000;
        end else begin
            edges    <= edges + 1;
            sec_hist <= {sec_hist[1:0], sec};
        end
    end

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        checks++; if (an !== 4'b1111) begin failures++; $display("FAIL %s_an got=%b exp=1111", tag, an); end
        checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL %s_seg got=%b exp=1111111", tag, seg); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL %s_dp got=%b exp=1", tag, dp); end
        checks++; if (mt !== 4'd0) begin failures++; $display("FAIL %s_tens got=%0d exp=0", tag, mt); end
        checks++; if (mo !== 4'd0) begin failures++; $display("FAIL %s_ones got=%0d exp=0", tag, mo); end
        checks++; if (cd !== 1'b0) begin failures++; $display("FAIL %s_conv_done got=%b exp=0", tag, cd); end
    endtask

    // Scan check with stable digit values: the slot follows edges since reset.
    task automatic check_scan(input int n, input int tens, input int ones, input int hr, input bit toggle_sec);
        int         slot;
        logic [3:0] e_an;
        logic [6:0] e_seg, e_seg_b;
        logic       e_dp;
        for (int i = 0; i < n; i++) begin
            if (toggle_sec && ($urandom_range(0, 2) == 0)) sec = ~sec;
            @(posedge clk); #1;
            slot  = ((edges - 1) / RD) % 3;
            e_an  = (slot == 0) ? 4'b1110 : (slot == 1) ? 4'b1101 : 4'b1011;
            e_seg = (slot == 0) ? enc(ones) : (slot == 1) ? enc(tens) : enc(hr);
            e_seg_b = (slot == 1 && tens == 0) ? 7'b1111111 : e_seg;
            e_dp  = !(slot == 2 && sec_hist[2]);
            checks++; if (an !== e_an) begin failures++; $display("FAIL scan_an edge=%0d got=%b exp=%b", edges, an, e_an); end
            checks++; if (seg !== e_seg) begin failures++; $display("FAIL scan_seg edge=%0d slot=%0d got=%b exp=%b", edges, slot, seg, e_seg); end
            checks++; if (seg_b !== e_seg_b) begin failures++; $display("FAIL scan_seg_lz edge=%0d slot=%0d got=%b exp=%b", edges, slot, seg_b, e_seg_b); end
            checks++; if (dp !== e_dp) begin failures++; $display("FAIL scan_dp edge=%0d slot=%0d got=%b exp=%b", edges, slot, dp, e_dp); end
            checks++; if (cd !== 1'b0) begin failures++; $display("FAIL scan_quiet edge=%0d conv_done=%b exp=0", edges, cd); end
        end
    endtask

    task automatic wait_conv(input int budget, input string tag, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            if (cd === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s_timeout conv_done not seen within %0d cycles", tag, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; minutes = 6'd0; hours = 1'b0; sec = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        check_scan(24, 0, 0, 0, 1'b0);
        last_m = 0; last_h = 0;
    endtask

    task automatic test_conv_37();
        minutes = 6'd37;
        for (int i = 0; i <= 9; i++) begin
            @(posedge clk); #1;
            checks++;
            if (cd !== (i == 9)) begin
                failures++; $display("FAIL conv37_latency edge=k+%0d got=%b exp=%b", i, cd, (i == 9));
            end
        end
        checks++; if (mt !== 4'd3) begin failures++; $display("FAIL conv37_tens got=%0d exp=3", mt); end
        checks++; if (mo !== 4'd7) begin failures++; $display("FAIL conv37_ones got=%0d exp=7", mo); end
        last_m = 37; last_h = 0;
        check_scan(24, 3, 7, 0, 1'b1);
    endtask

    task automatic test_hour_rollover();
        bit got;
        int pulses;
        minutes = 6'd59; hours = 1'b0;
        wait_conv(20, "roll59", got);
        checks++; if (mt !== 4'd5 || mo !== 4'd9) begin failures++; $display("FAIL roll59_value got=%0d%0d exp=59", mt, mo); end
        repeat (2) @(posedge clk);
        #1;
        minutes = 6'd0; hours = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (cd === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL roll_pulses got=%0d exp=1", pulses); end
        checks++; if (mt !== 4'd0 || mo !== 4'd0) begin failures++; $display("FAIL roll_value got=%0d%0d exp=00", mt, mo); end
        last_m = 0; last_h = 1;
        check_scan(24, 0, 0, 1, 1'b1);
    endtask

    task automatic test_change_during_conv();
        int pulses;
        int t_q[$];
        int o_q[$];
        minutes = 6'd12; hours = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        minutes = 6'd45;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (cd === 1'b1) begin
                pulses++; t_q.push_back(int'(mt)); o_q.push_back(int'(mo));
            end
        end
        checks++;
        if (pulses != 2) begin
            failures++; $display("FAIL chg_pulses got=%0d exp=2", pulses);
        end else begin
            checks++; if (t_q[0] != 1 || o_q[0] != 2) begin failures++; $display("FAIL chg_first got=%0d%0d exp=12", t_q[0], o_q[0]); end
            checks++; if (t_q[1] != 4 || o_q[1] != 5) begin failures++; $display("FAIL chg_second got=%0d%0d exp=45", t_q[1], o_q[1]); end
        end
        last_m = 45; last_h = 1;
    endtask

    task automatic test_random();
        bit got;
        int m, h;
        for (int it = 0; it < 12; it++) begin
            m = (it < 4) ? (60 + it) : int'($urandom_range(0, 63));
            h = int'($urandom_range(0, 1));
            if (m == last_m && h == last_h) m = (m + 1) % 64;
            minutes = 6'(m); hours = h[0];
            wait_conv(20, "rand", got);
            if (got) begin
                checks++; if (mt !== 4'(m / 10)) begin failures++; $display("FAIL rand_tens m=%0d got=%0d exp=%0d", m, mt, m / 10); end
                checks++; if (mo !== 4'(m % 10)) begin failures++; $display("FAIL rand_ones m=%0d got=%0d exp=%0d", m, mo, m % 10); end
            end
            last_m = m; last_h = h;
            check_scan(14, m / 10, m % 10, h, 1'b1);
        end
    endtask

    task automatic test_reset_mid_conv();
        int m;
        int pulses;
        m = (last_m == 23 && last_h == 0) ? 24 : 23;
        minutes = 6'(m); hours = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (cd === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL midrst_pulses got=%0d exp=1", pulses); end
        checks++; if (mt !== 4'(m / 10) || mo !== 4'(m % 10)) begin failures++; $display("FAIL midrst_value got=%0d%0d exp=%0d", mt, mo, m); end
        last_m = m; last_h = 0;
        check_scan(12, m / 10, m % 10, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_conv_37();
        test_hour_rollover();
        test_change_during_conv();
        test_random();
        test_reset_mid_conv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
